// File: rtl/mem_bus_tracer.sv
// Memory-bus transaction tracer: edge-detected, address-filtered bus events go into a
// circular trace buffer, and an address-match trigger stops capture POST_TRIG entries later.
module mem_bus_tracer #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int POST_TRIG  = 8,
  parameter int MODE       = 0,
  localparam int IW        = $clog2(DEPTH),
  localparam int EW        = 1 + ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] BUS_ADDR,
  input  logic [DATA_WIDTH-1:0] BUS_DATA,
  input  logic                  BUS_READ,
  input  logic                  BUS_WRITE,
  input  logic                  ARM,
  input  logic [ADDR_WIDTH-1:0] WIN_LO,
  input  logic [ADDR_WIDTH-1:0] WIN_HI,
  input  logic [ADDR_WIDTH-1:0] TRIG_ADDR,
  input  logic [IW-1:0]         RD_IDX,
  output logic [EW-1:0]         RD_ENTRY,
  output logic [IW:0]           COUNT,
  output logic [1:0]            STATE,
  output logic                  DONE,
  output logic                  OVERFLOW,
  output logic                  PROTO_ERR
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [IW:0]   DEPTH_C = (IW+1)'(DEPTH);
  localparam logic [IW-1:0] POST_C  = IW'(POST_TRIG);

  state_t        state_q, state_d;
  logic [IW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IW:0]   count_q, count_d;
  logic [IW-1:0] post_q, post_d;
  logic          ovf_q, ovf_d;
  logic          perr_q, perr_d;
  logic          rd_q, wr_q;
  logic          mem_we;

  logic [EW-1:0] mem [DEPTH];

  logic evt, in_win, trig, qual, full, capturing;

  // A single strobe rising out of an idle bus is one event; overlapping strobes never are.
  assign evt       = !rd_q && !wr_q && (BUS_READ ^ BUS_WRITE);
  assign in_win    = (BUS_ADDR >= WIN_LO) && (BUS_ADDR <= WIN_HI);
  assign trig      = evt && BUS_WRITE && (BUS_ADDR == TRIG_ADDR) && (state_q == S_ARMED);
  assign qual      = evt && (in_win || trig);
  assign full      = (count_q == DEPTH_C);
  assign capturing = (state_q == S_ARMED) || (state_q == S_POST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      count_q  <= '0;
      post_q   <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      post_q   <= post_d;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
      rd_q     <= BUS_READ;
      wr_q     <= BUS_WRITE;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[wr_ptr_q] <= {BUS_WRITE, BUS_ADDR, BUS_DATA};
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    post_d   = post_q;
    ovf_d    = ovf_q;
    perr_d   = perr_q;
    mem_we   = 1'b0;
    if (ARM) begin
      state_d  = S_ARMED;
      wr_ptr_d = '0;
      count_d  = '0;
      post_d   = '0;
      ovf_d    = 1'b0;
      perr_d   = 1'b0;
    end else if (capturing) begin
      if (BUS_READ && BUS_WRITE) perr_d = 1'b1;
      if (qual) begin
        // Stop-when-full drops the event, including a trigger arriving on the same edge.
        if (full && (MODE == 1)) begin
          state_d = S_DONE;
        end else begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (full) ovf_d = 1'b1;
          else      count_d = count_q + 1'b1;
          if (state_q == S_ARMED) begin
            if (trig) begin
              if (POST_TRIG == 0) begin
                state_d = S_DONE;
              end else begin
                state_d = S_POST;
                post_d  = POST_C;
              end
            end
          end else begin
            post_d = post_q - 1'b1;
            if (post_q == IW'(1)) state_d = S_DONE;
          end
        end
      end
    end
  end

  logic [IW-1:0] oldest, rd_addr;
  assign oldest  = full ? wr_ptr_q : '0;
  assign rd_addr = oldest + RD_IDX;

  always_comb begin
    RD_ENTRY = '0;
    if ({1'b0, RD_IDX} < count_q) RD_ENTRY = mem[rd_addr];
  end

  assign COUNT     = count_q;
  assign STATE     = state_q;
  assign DONE      = (state_q == S_DONE);
  assign OVERFLOW  = ovf_q;
  assign PROTO_ERR = perr_q;

endmodule

// File: tb/tb_mem_bus_tracer.sv
// Directed bench for mem_bus_tracer: a wrap-mode and a stop-when-full instance share
// stimulus, with expected values worked out by hand for each scenario.
module tb_mem_bus_tracer;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int EW = 1 + AW + DW;

  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] BUS_ADDR;
  logic [DW-1:0] BUS_DATA;
  logic          BUS_READ, BUS_WRITE, ARM;
  logic [AW-1:0] WIN_LO, WIN_HI, TRIG_ADDR;
  logic [3:0]    RD_IDX;

  logic [EW-1:0] e0, e1;
  logic [4:0]    c0, c1;
  logic [1:0]    s0, s1;
  logic          d0, d1, o0, o1, p0, p1;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  mem_bus_tracer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16), .POST_TRIG(3), .MODE(0)) u0 (
    .CLK(CLK), .RST(RST), .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA), .BUS_READ(BUS_READ),
    .BUS_WRITE(BUS_WRITE), .ARM(ARM), .WIN_LO(WIN_LO), .WIN_HI(WIN_HI), .TRIG_ADDR(TRIG_ADDR),
    .RD_IDX(RD_IDX), .RD_ENTRY(e0), .COUNT(c0), .STATE(s0), .DONE(d0), .OVERFLOW(o0),
    .PROTO_ERR(p0));

  mem_bus_tracer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16), .POST_TRIG(3), .MODE(1)) u1 (
    .CLK(CLK), .RST(RST), .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA), .BUS_READ(BUS_READ),
    .BUS_WRITE(BUS_WRITE), .ARM(ARM), .WIN_LO(WIN_LO), .WIN_HI(WIN_HI), .TRIG_ADDR(TRIG_ADDR),
    .RD_IDX(RD_IDX), .RD_ENTRY(e1), .COUNT(c1), .STATE(s1), .DONE(d1), .OVERFLOW(o1),
    .PROTO_ERR(p1));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_arm();
    ARM = 1'b1;
    tick();
    ARM = 1'b0;
  endtask

  // One-cycle strobe followed by one idle cycle, so consecutive calls are separate events.
  task automatic bus_op(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    BUS_ADDR  = a;
    BUS_DATA  = d;
    BUS_READ  = !w;
    BUS_WRITE = w;
    tick();
    BUS_READ  = 1'b0;
    BUS_WRITE = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    RD_IDX = 4'd0;
    checks++; if (s0 !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", s0); end
    checks++; if (c0 !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", c0); end
    checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", d0); end
    checks++; if (o0 !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", o0); end
    checks++; if (p0 !== 1'b0) begin errors++; $display("FAIL reset_perr got=%0b exp=0", p0); end
    checks++; if (e0 !== '0) begin errors++; $display("FAIL reset_entry got=%h exp=0", e0); end
  endtask

  task automatic test_basic();
    WIN_LO = 26'h1000; WIN_HI = 26'h10FF; TRIG_ADDR = 26'h2000;
    do_arm();
    bus_op(1'b1, 26'h1000, 32'hDEADBEEF);
    RD_IDX = 4'd0; #1;
    checks++; if (c0 !== 5'd1) begin errors++; $display("FAIL basic_count got=%0d exp=1", c0); end
    checks++; if (e0 !== {1'b1, 26'h1000, 32'hDEADBEEF})
      begin errors++; $display("FAIL basic_entry got=%h exp=%h", e0, {1'b1, 26'h1000, 32'hDEADBEEF}); end
    checks++; if (s0 !== 2'd1) begin errors++; $display("FAIL basic_state got=%0d exp=1", s0); end
    RD_IDX = 4'd1; #1;
    checks++; if (e0 !== '0) begin errors++; $display("FAIL basic_beyond_count got=%h exp=0", e0); end
  endtask

  task automatic test_wrap();
    WIN_LO = 26'h0; WIN_HI = 26'hFF; TRIG_ADDR = 26'h2000;
    do_arm();
    for (int i = 0; i < 20; i++) bus_op(1'b0, AW'(i), 32'h100 + 32'(i));
    checks++; if (c0 !== 5'd16) begin errors++; $display("FAIL wrap_count got=%0d exp=16", c0); end
    checks++; if (o0 !== 1'b1) begin errors++; $display("FAIL wrap_ovf got=%0b exp=1", o0); end
    RD_IDX = 4'd0; #1;
    checks++; if (e0 !== {1'b0, 26'd4, 32'h104})
      begin errors++; $display("FAIL wrap_oldest got=%h exp=%h", e0, {1'b0, 26'd4, 32'h104}); end
    RD_IDX = 4'd15; #1;
    checks++; if (e0 !== {1'b0, 26'd19, 32'h113})
      begin errors++; $display("FAIL wrap_newest got=%h exp=%h", e0, {1'b0, 26'd19, 32'h113}); end
    checks++; if (s0 !== 2'd1) begin errors++; $display("FAIL wrap_state got=%0d exp=1", s0); end
  endtask

  task automatic test_mode1_full();
    WIN_LO = 26'h0; WIN_HI = 26'hFF; TRIG_ADDR = 26'h2000;
    do_arm();
    for (int i = 0; i < 16; i++) bus_op(1'b0, AW'(i), 32'h200 + 32'(i));
    checks++; if (s1 !== 2'd1) begin errors++; $display("FAIL m1_state_at16 got=%0d exp=1", s1); end
    bus_op(1'b0, 26'd16, 32'h210);
    checks++; if (c1 !== 5'd16) begin errors++; $display("FAIL m1_count got=%0d exp=16", c1); end
    checks++; if (s1 !== 2'd3) begin errors++; $display("FAIL m1_state got=%0d exp=3", s1); end
    checks++; if (d1 !== 1'b1) begin errors++; $display("FAIL m1_done got=%0b exp=1", d1); end
    checks++; if (o1 !== 1'b0) begin errors++; $display("FAIL m1_ovf got=%0b exp=0", o1); end
    RD_IDX = 4'd15; #1;
    checks++; if (e1 !== {1'b0, 26'd15, 32'h20F})
      begin errors++; $display("FAIL m1_last got=%h exp=%h", e1, {1'b0, 26'd15, 32'h20F}); end
    RD_IDX = 4'd0; #1;
    checks++; if (e1 !== {1'b0, 26'd0, 32'h200})
      begin errors++; $display("FAIL m1_first got=%h exp=%h", e1, {1'b0, 26'd0, 32'h200}); end
  endtask

  task automatic test_trigger();
    WIN_LO = 26'h0; WIN_HI = 26'hFF; TRIG_ADDR = 26'h2000;
    do_arm();
    bus_op(1'b1, 26'h2000, 32'hAA);
    checks++; if (s0 !== 2'd2) begin errors++; $display("FAIL trig_post got=%0d exp=2", s0); end
    checks++; if (c0 !== 5'd1) begin errors++; $display("FAIL trig_count got=%0d exp=1", c0); end
    for (int i = 0; i < 5; i++) begin
      bus_op(1'b0, 26'h10 + AW'(i), 32'h300 + 32'(i));
      if (i == 1) begin
        checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL trig_done_early got=%0b exp=0", d0); end
      end
      if (i == 2) begin
        checks++; if (d0 !== 1'b1) begin errors++; $display("FAIL trig_done_third got=%0b exp=1", d0); end
      end
    end
    checks++; if (c0 !== 5'd4) begin errors++; $display("FAIL trig_final_count got=%0d exp=4", c0); end
    checks++; if (s0 !== 2'd3) begin errors++; $display("FAIL trig_final_state got=%0d exp=3", s0); end
    RD_IDX = 4'd0; #1;
    checks++; if (e0 !== {1'b1, 26'h2000, 32'hAA})
      begin errors++; $display("FAIL trig_entry0 got=%h exp=%h", e0, {1'b1, 26'h2000, 32'hAA}); end
    RD_IDX = 4'd3; #1;
    checks++; if (e0 !== {1'b0, 26'h12, 32'h302})
      begin errors++; $display("FAIL trig_entry3 got=%h exp=%h", e0, {1'b0, 26'h12, 32'h302}); end
  endtask

  task automatic test_empty_window();
    WIN_LO = 26'h100; WIN_HI = 26'h10; TRIG_ADDR = 26'h2000;
    do_arm();
    bus_op(1'b0, 26'h50, 32'h1);
    checks++; if (c0 !== 5'd0) begin errors++; $display("FAIL empty_win_count got=%0d exp=0", c0); end
    bus_op(1'b1, 26'h2000, 32'h2);
    checks++; if (c0 !== 5'd1) begin errors++; $display("FAIL empty_win_trig got=%0d exp=1", c0); end
  endtask

  task automatic test_arm_priority();
    WIN_LO = 26'h0; WIN_HI = 26'hFF;
    BUS_ADDR = 26'h5; BUS_WRITE = 1'b1; ARM = 1'b1;
    tick();
    ARM = 1'b0; BUS_WRITE = 1'b0;
    tick();
    checks++; if (c0 !== 5'd0) begin errors++; $display("FAIL arm_prio_count got=%0d exp=0", c0); end
    checks++; if (s0 !== 2'd1) begin errors++; $display("FAIL arm_prio_state got=%0d exp=1", s0); end
  endtask

  task automatic test_proto();
    WIN_LO = 26'h1000; WIN_HI = 26'h10FF; TRIG_ADDR = 26'h2000;
    do_arm();
    BUS_ADDR = 26'h1000; BUS_READ = 1'b1; BUS_WRITE = 1'b1;
    tick();
    BUS_READ = 1'b0; BUS_WRITE = 1'b0;
    tick();
    checks++; if (p0 !== 1'b1) begin errors++; $display("FAIL proto_err got=%0b exp=1", p0); end
    checks++; if (c0 !== 5'd0) begin errors++; $display("FAIL proto_count got=%0d exp=0", c0); end
    bus_op(1'b0, 26'h3000, 32'h5);
    checks++; if (c0 !== 5'd0) begin errors++; $display("FAIL outwin_count got=%0d exp=0", c0); end
    BUS_ADDR = 26'h1001; BUS_READ = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    BUS_READ = 1'b0;
    tick();
    checks++; if (c0 !== 5'd1) begin errors++; $display("FAIL held_count got=%0d exp=1", c0); end
    checks++; if (p0 !== 1'b1) begin errors++; $display("FAIL proto_sticky got=%0b exp=1", p0); end
  endtask

  task automatic test_reset_mid();
    WIN_LO = 26'h0; WIN_HI = 26'hFF; TRIG_ADDR = 26'h2000;
    do_arm();
    bus_op(1'b1, 26'h2000, 32'h7);
    bus_op(1'b0, 26'h1, 32'h8);
    #2 RST = 1'b0;
    #1;
    RD_IDX = 4'd0; #1;
    checks++; if (s0 !== 2'd0) begin errors++; $display("FAIL rstmid_state got=%0d exp=0", s0); end
    checks++; if (c0 !== 5'd0) begin errors++; $display("FAIL rstmid_count got=%0d exp=0", c0); end
    checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%0b exp=0", d0); end
    checks++; if (e0 !== '0) begin errors++; $display("FAIL rstmid_entry got=%h exp=0", e0); end
    tick();
    RST = 1'b1;
    tick();
    do_arm();
    checks++; if (s0 !== 2'd1) begin errors++; $display("FAIL rearm_state got=%0d exp=1", s0); end
    checks++; if (c0 !== 5'd0) begin errors++; $display("FAIL rearm_count got=%0d exp=0", c0); end
  endtask

  initial begin
    RST = 1'b0; ARM = 1'b0; BUS_READ = 1'b0; BUS_WRITE = 1'b0;
    BUS_ADDR = '0; BUS_DATA = '0; WIN_LO = '0; WIN_HI = '0; TRIG_ADDR = '0; RD_IDX = '0;
    tick(); tick();
    test_reset();
    RST = 1'b1;
    tick();
    test_basic();
    test_wrap();
    test_mode1_full();
    test_trigger();
    test_empty_window();
    test_arm_priority();
    test_proto();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_bus_tracer.md
# mem_bus_tracer

Parametrised memory-bus transaction tracer for the DA_VINCI system. It sits beside the processor–memory interface, watches READ/WRITE/ADDR/DATA, and records address-filtered transactions into a circular trace buffer. An address-match trigger stops capture a programmable number of entries later. Captured history is exposed on an indexed readout port, so benches and debug logic can inspect bus activity without dumping all of memory.

## Interface
- ADDR_WIDTH, 26: bus address width.
- DATA_WIDTH, 32: bus data width.
- DEPTH, 16: trace entries; power of 2, ≥2.
- POST_TRIG, 8: entries captured after the trigger entry; range 0..DEPTH-1.
- MODE, 0: 0 = wrap (overwrite oldest), 1 = stop when buffer full.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- BUS_ADDR  in  ADDR_WIDTH  memory bus address.
- BUS_DATA  in  DATA_WIDTH  memory bus data as seen on the bus.
- BUS_READ  in  1  bus read strobe.
- BUS_WRITE  in  1  bus write strobe.
- ARM  in  1  clears the buffer and starts capture.
- WIN_LO  in  ADDR_WIDTH  capture window low bound, inclusive.
- WIN_HI  in  ADDR_WIDTH  capture window high bound, inclusive.
- TRIG_ADDR  in  ADDR_WIDTH  trigger address; a write to it fires the trigger.
- RD_IDX  in  log2(DEPTH)  readout index; 0 = oldest entry.
- RD_ENTRY  out  1+ADDR_WIDTH+DATA_WIDTH  {is_write, addr, data} at RD_IDX.
- COUNT  out  log2(DEPTH)+1  valid entries; saturates at DEPTH.
- STATE  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- DONE  out  1  high in DONE.
- OVERFLOW  out  1  sticky; an entry was overwritten.
- PROTO_ERR  out  1  sticky; READ and WRITE were both high.

## Operation
- Event definition: an event occurs on a cycle where the registered previous READ/WRITE were both 0 and exactly one of them is now 1.
  - A cycle with READ=WRITE=1 is never an event. It sets PROTO_ERR in ARMED or POST.
  - Edge-detect registers run in every state.
- Qualifying event: BUS_ADDR is in [WIN_LO, WIN_HI], or the event is the trigger.
  - If WIN_LO > WIN_HI, the window is empty; only the trigger qualifies.
- Trigger: a write event with BUS_ADDR == TRIG_ADDR while in ARMED. The trigger entry is always recorded.
- IDLE: no capture. ARM → ARMED.
- ARMED:
  - Each qualifying event writes an entry at wr_ptr, then wr_ptr increments mod DEPTH and COUNT increments (saturating).
  - When COUNT == DEPTH before a write: MODE 0 overwrites the oldest entry and sets OVERFLOW; MODE 1 drops the event and goes to DONE.
  - Trigger with POST_TRIG == 0 → DONE. Trigger otherwise → POST, with post_cnt = POST_TRIG.
- POST:
  - Same capture rules as ARMED; further trigger matches are ordinary entries.
  - Each recorded entry decrements post_cnt; when it reaches 0 → DONE.
  - A MODE 1 full condition → DONE.
- DONE: no capture; buffer frozen. ARM → ARMED.
- ARM in any state: wr_ptr, COUNT, post_cnt, OVERFLOW and PROTO_ERR are cleared; STATE = ARMED. ARM has priority over a same-cycle event, which is dropped.
- Readout is combinational:
  - oldest = wr_ptr when COUNT == DEPTH, else 0.
  - RD_ENTRY = mem[(oldest + RD_IDX) mod DEPTH].
  - When RD_IDX ≥ COUNT, RD_ENTRY = 0.

## Timing
- Reset: STATE = IDLE; COUNT = 0; DONE = 0; OVERFLOW = 0; PROTO_ERR = 0; wr_ptr = 0; edge registers = 0. RD_ENTRY reads 0 because COUNT = 0. Buffer contents need not be cleared.
- Reset mid-capture takes effect immediately (asynchronous); no partial entry is kept.
- Capture latency: the event is sampled at the rising edge where the strobe is first high. The entry, COUNT, STATE and DONE are visible after that same edge.
- A strobe held high for N cycles yields one entry. Back-to-back events need the strobe low for at least one cycle.
- ARM is level-sampled at the edge; holding it high keeps re-clearing.
- DONE rises in the same edge that records the final post-trigger entry. With POST_TRIG = 0, DONE rises on the trigger edge.
- MODE 1 full and trigger on the same edge: the trigger is dropped and STATE → DONE.

## Test plan
- Reset then ARM; write 0x1000 with window 0x1000–0x10FF and TRIG_ADDR 0x2000 → COUNT = 1, RD_IDX 0 = {1, 0x1000, data}, STATE = ARMED.
- DEPTH 16, MODE 0, 20 in-window reads of addresses 0..19 → COUNT = 16, OVERFLOW = 1, RD_IDX 0 addr = 4, RD_IDX 15 addr = 19.
- POST_TRIG 3, write to TRIG_ADDR, then 5 in-window events → exactly 3 post entries recorded; DONE rises on the 3rd; COUNT = 4.
- MODE 1, DEPTH 16, 17 in-window events → COUNT = 16, STATE = DONE, 17th event absent, OVERFLOW = 0.
- READ and WRITE high together; out-of-window read; strobe held high 5 cycles → PROTO_ERR = 1; COUNT increments only for the held strobe, by 1.
- RST low mid-POST, then high, then ARM → all outputs at reset values, then STATE = ARMED with COUNT = 0.
